// File: rtl/de_sel_pkg.sv
// Shared definitions for the de_selector_nch family: mode encodings, idle level, select width.
package de_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Lanes drive active-low loads, so the idle word is all ones.
    localparam logic IDLE_BIT = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/de_sel_scan_cnt.sv
// Modulo-CH up counter with enable and synchronous clear; clear has priority over the advance.
module de_sel_scan_cnt
    import de_sel_pkg::*;
#(
    parameter int unsigned CH = 8,
    parameter int unsigned SW = clog2(CH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [SW-1:0] cnt_o
);

    logic [SW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == SW'(CH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/de_selector_nch.sv
// Registered 1-to-CH demultiplexer with direct/auto-scan select and hold/pulse lanes.
// Optional sticky out-of-range error flag enabled by defining DE_SEL_ERR_EN.
module de_selector_nch
    import de_sel_pkg::*;
#(
    parameter int unsigned CH   = 8,
    parameter int unsigned DW   = 1,
    parameter int unsigned SW   = clog2(CH),
    parameter bit          HOLD = 1'b1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    input  logic [DW-1:0]    iData,
    input  logic [SW-1:0]    iS,
    input  logic             iMode,
    input  logic             iScanRst,
`ifdef DE_SEL_ERR_EN
    input  logic             iErrClr,
    output logic             oErr,
`endif
    output logic [CH*DW-1:0] oZ,
    output logic             oValid,
    output logic [SW-1:0]    oSel,
    output logic [SW-1:0]    oScan
);

    logic [SW-1:0]    scan_cnt;
    logic [SW-1:0]    tgt;
    logic [CH-1:0]    hit;
    logic             accept;

    logic [CH*DW-1:0] z_q, z_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    sel_q, sel_d;

    de_sel_scan_cnt #(
        .CH (CH),
        .SW (SW)
    ) u_scan_cnt (
        .clk_i  (iClk),
        .rst_ni (iRst_n),
        .clr_i  (iScanRst),
        .en_i   (iValid & (iMode == MODE_SCAN)),
        .cnt_o  (scan_cnt)
    );

    // An empty hit vector means iS named a lane that does not exist.
    always_comb begin
        tgt = (iMode == MODE_SCAN) ? scan_cnt : iS;
        hit = '0;
        for (int k = 0; k < CH; k++) begin
            hit[k] = (tgt == SW'(k));
        end
        accept = iValid & (|hit);
    end

    always_comb begin
        z_d = HOLD ? z_q : {(CH * DW){IDLE_BIT}};
        for (int k = 0; k < CH; k++) begin
            if (accept && hit[k]) begin
                z_d[k*DW +: DW] = iData;
            end
        end
        valid_d = accept;
        sel_d   = accept ? tgt : sel_q;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            z_q     <= {(CH * DW){IDLE_BIT}};
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            z_q     <= z_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign oZ     = z_q;
    assign oValid = valid_q;
    assign oSel   = sel_q;
    assign oScan  = scan_cnt;

`ifdef DE_SEL_ERR_EN
    logic err_q, err_d;

    // A new out-of-range word wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (iValid && (iMode == MODE_DIRECT) && !(|hit)) begin
            err_d = 1'b1;
        end else if (iErrClr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oErr = err_q;
`endif

endmodule

// File: tb/tb_de_selector_nch.sv
// Bench: three configurations (CH8/hold, CH8/pulse, CH6/DW2/hold) against a behavioural model.
module tb_de_selector_nch;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, valid, mode, scan_rst, err_clr;
    logic [2:0] s;
    logic [1:0] data;

    logic [7:0]  z_a, z_b;
    logic [11:0] z_c;
    logic        v_a, v_b, v_c;
    logic [2:0]  sel_a, sel_b, sel_c, scan_a, scan_b, scan_c;
`ifdef DE_SEL_ERR_EN
    logic        err_a, err_b, err_c;
`endif

    de_selector_nch #(.CH(8), .DW(1), .HOLD(1'b1)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iData(data[0]), .iS(s), .iMode(mode),
        .iScanRst(scan_rst),
`ifdef DE_SEL_ERR_EN
        .iErrClr(err_clr), .oErr(err_a),
`endif
        .oZ(z_a), .oValid(v_a), .oSel(sel_a), .oScan(scan_a)
    );

    de_selector_nch #(.CH(8), .DW(1), .HOLD(1'b0)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iData(data[0]), .iS(s), .iMode(mode),
        .iScanRst(scan_rst),
`ifdef DE_SEL_ERR_EN
        .iErrClr(err_clr), .oErr(err_b),
`endif
        .oZ(z_b), .oValid(v_b), .oSel(sel_b), .oScan(scan_b)
    );

    de_selector_nch #(.CH(6), .DW(2), .HOLD(1'b1)) dut_c (
        .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iData(data), .iS(s), .iMode(mode),
        .iScanRst(scan_rst),
`ifdef DE_SEL_ERR_EN
        .iErrClr(err_clr), .oErr(err_c),
`endif
        .oZ(z_c), .oValid(v_c), .oSel(sel_c), .oScan(scan_c)
    );

    int unsigned m_ch[3]   = '{8, 8, 6};
    bit          m_hold[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_dw[3]   = '{1, 1, 2};
    logic [1:0]  m_lane[3][16];
    logic        m_v[3];
    int unsigned m_sel[3];
    int unsigned m_scan[3];
    logic        m_err[3];

    int n_cmp  = 0;
    int n_fail = 0;

    // Advance the reference model by one clock using the current inputs, then clock the DUTs.
    task automatic apply();
        for (int i = 0; i < 3; i++) begin
            int unsigned t;
            bit ok;
            if (!rst_n) begin
                for (int k = 0; k < 16; k++) m_lane[i][k] = 2'b11;
                m_v[i] = 1'b0; m_sel[i] = 0; m_scan[i] = 0; m_err[i] = 1'b0;
            end else begin
                t  = mode ? m_scan[i] : int'(s);
                ok = valid && (t < m_ch[i]);
                for (int k = 0; k < 16; k++) begin
                    if (ok && k == t) m_lane[i][k] = data;
                    else if (!m_hold[i]) m_lane[i][k] = 2'b11;
                end
                m_v[i] = ok;
                if (ok) m_sel[i] = t;
                if (valid && !mode && int'(s) >= m_ch[i]) m_err[i] = 1'b1;
                else if (err_clr) m_err[i] = 1'b0;
                if (scan_rst) m_scan[i] = 0;
                else if (valid && mode) m_scan[i] = (m_scan[i] + 1) % m_ch[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_z(int i);
        logic [31:0] z;
        z = '0;
        for (int k = 0; k < int'(m_ch[i]); k++)
            for (int b = 0; b < int'(m_dw[i]); b++)
                z[k * int'(m_dw[i]) + b] = m_lane[i][k][b];
        return z;
    endfunction

    function automatic logic [31:0] get_z(int i);
        case (i)
            0:       return {24'b0, z_a};
            1:       return {24'b0, z_b};
            default: return {20'b0, z_c};
        endcase
    endfunction

    function automatic logic get_v(int i);
        case (i)
            0:       return v_a;
            1:       return v_b;
            default: return v_c;
        endcase
    endfunction

    function automatic logic [2:0] get_sel(int i);
        case (i)
            0:       return sel_a;
            1:       return sel_b;
            default: return sel_c;
        endcase
    endfunction

    function automatic logic [2:0] get_scan(int i);
        case (i)
            0:       return scan_a;
            1:       return scan_b;
            default: return scan_c;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; apply();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; data = 2'b00; mode = 1'b1; scan_rst = 1'b0; s = 3'd2;
        apply(); apply();
        n_cmp++;
        if (z_a !== 8'hFF) begin n_fail++; $display("FAIL reset_z_a got %h want ff", z_a); end
        n_cmp++;
        if (z_c !== 12'hFFF) begin n_fail++; $display("FAIL reset_z_c got %h want fff", z_c); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (get_v(i) !== 1'b0 || get_sel(i) !== 3'd0 || get_scan(i) !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_ctl[%0d] got v=%b sel=%0d scan=%0d want 0/0/0",
                         i, get_v(i), get_sel(i), get_scan(i));
            end
        end
        rst_n = 1'b1; valid = 1'b0;
    endtask

    task automatic test_direct_route();
        do_reset();
        mode = 1'b0; s = 3'd3; data = 2'b00; valid = 1'b1; scan_rst = 1'b0;
        apply();
        n_cmp++;
        if (z_a !== 8'hF7 || v_a !== 1'b1 || sel_a !== 3'd3) begin
            n_fail++;
            $display("FAIL direct_hold got z=%h v=%b sel=%0d want f7/1/3", z_a, v_a, sel_a);
        end
        n_cmp++;
        if (z_b !== 8'hF7 || v_b !== 1'b1) begin
            n_fail++; $display("FAIL direct_pulse got z=%h v=%b want f7/1", z_b, v_b);
        end
        valid = 1'b0;
        apply();
        n_cmp++;
        if (z_a !== 8'hF7 || v_a !== 1'b0 || sel_a !== 3'd3) begin
            n_fail++;
            $display("FAIL hold_keep got z=%h v=%b sel=%0d want f7/0/3", z_a, v_a, sel_a);
        end
        n_cmp++;
        if (z_b !== 8'hFF || v_b !== 1'b0) begin
            n_fail++; $display("FAIL pulse_idle got z=%h v=%b want ff/0", z_b, v_b);
        end
    endtask

    task automatic test_scan_wrap();
        do_reset();
        mode = 1'b1; valid = 1'b1; data = 2'b00; scan_rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            apply();
            n_cmp++;
            if (sel_c !== 3'(i % 6) || scan_c !== 3'((i + 1) % 6) || v_c !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_wrap[%0d] got sel=%0d scan=%0d v=%b want %0d/%0d/1",
                         i, sel_c, scan_c, v_c, i % 6, (i + 1) % 6);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_scan_clear_collision();
        do_reset();
        mode = 1'b1; valid = 1'b1; data = 2'b11; scan_rst = 1'b0;
        repeat (4) apply();
        data = 2'b01; scan_rst = 1'b1;
        apply();
        n_cmp++;
        if (sel_c !== 3'd4 || scan_c !== 3'd0 || z_c[9:8] !== 2'b01 || v_c !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_clr got sel=%0d scan=%0d lane4=%b v=%b want 4/0/01/1",
                     sel_c, scan_c, z_c[9:8], v_c);
        end
        scan_rst = 1'b0; valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [11:0] prev;
        do_reset();
        mode = 1'b0; s = 3'd2; data = 2'b10; valid = 1'b1; scan_rst = 1'b0; err_clr = 1'b0;
        apply();
        prev = z_c;
        s = 3'd7; data = 2'b00;
        apply();
        n_cmp++;
        if (z_c !== prev || v_c !== 1'b0 || sel_c !== 3'd2) begin
            n_fail++;
            $display("FAIL oor_drop got z=%h v=%b sel=%0d want %h/0/2", z_c, v_c, sel_c, prev);
        end
        valid = 1'b0;
        apply();
`ifdef DE_SEL_ERR_EN
        n_cmp++;
        if (err_c !== 1'b1 || err_a !== 1'b0) begin
            n_fail++; $display("FAIL oor_err_sticky got c=%b a=%b want 1/0", err_c, err_a);
        end
        err_clr = 1'b1;
        apply();
        n_cmp++;
        if (err_c !== 1'b0) begin
            n_fail++; $display("FAIL oor_err_clr got %b want 0", err_c);
        end
        err_clr = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            valid    = ($urandom_range(0, 9) < 7);
            mode     = $urandom_range(0, 1) == 1;
            scan_rst = ($urandom_range(0, 7) == 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            s        = 3'($urandom_range(0, 7));
            data     = 2'($urandom_range(0, 3));
            apply();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (get_z(i) !== exp_z(i) || get_v(i) !== m_v[i] ||
                    get_sel(i) !== 3'(m_sel[i]) || get_scan(i) !== 3'(m_scan[i])) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d got z=%h v=%b sel=%0d scan=%0d want %h/%b/%0d/%0d",
                             n, i, get_z(i), get_v(i), get_sel(i), get_scan(i),
                             exp_z(i), m_v[i], m_sel[i], m_scan[i]);
                end
            end
`ifdef DE_SEL_ERR_EN
            n_cmp++;
            if (err_a !== m_err[0] || err_b !== m_err[1] || err_c !== m_err[2]) begin
                n_fail++;
                $display("FAIL random_err[%0d] got %b%b%b want %b%b%b", n, err_a, err_b, err_c,
                         m_err[0], m_err[1], m_err[2]);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mode = 1'b0; scan_rst = 1'b0; err_clr = 1'b0;
        s = 3'd0; data = 2'b11;
        test_reset();
        test_direct_route();
        test_scan_wrap();
        test_scan_clear_collision();
        test_out_of_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
